// File: rtl/seg_pkg.sv
// Segment codes, FSM encoding and hex-to-segment helper shared by the scan driver.
package seg_pkg;

  // Active-low segment patterns, bit7 = dp, bits6..0 = g..a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = SEG_0;
      4'h1: seg_code = SEG_1;
      4'h2: seg_code = SEG_2;
      4'h3: seg_code = SEG_3;
      4'h4: seg_code = SEG_4;
      4'h5: seg_code = SEG_5;
      4'h6: seg_code = SEG_6;
      4'h7: seg_code = SEG_7;
      4'h8: seg_code = SEG_8;
      4'h9: seg_code = SEG_9;
      4'hA: seg_code = SEG_A;
      4'hB: seg_code = SEG_B;
      4'hC: seg_code = SEG_C;
      4'hD: seg_code = SEG_D;
      4'hE: seg_code = SEG_E;
      default: seg_code = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Load request and display outputs of the scan driver.
interface seg_scan_driver_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic              load;
  logic [DATA_W-1:0] value;
  logic              hex_mode;
  logic [DIGITS-1:0] dp_mask;
  logic              blank_lz;
  logic              busy;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

  modport master (output load, value, hex_mode, dp_mask, blank_lz,
                  input  busy, sel, seg);
  modport slave  (input  load, value, hex_mode, dp_mask, blank_lz,
                  output busy, sel, seg);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, DATA_W steps.
// The extra top nibble plus a sticky carry-out bit flag values that do not
// fit in DIGITS decimal digits.
module bin2bcd_seq #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS+3:0]   bcd
);
  localparam int BW = 4*DIGITS + 4;
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [BW-1:0]     acc, acc_adj;
  logic [CW-1:0]     cnt;
  logic              lost;

  // add 3 to every nibble that is 5 or more before it gets shifted
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS + 1; i++)
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
  end

  // shift one binary bit into the BCD accumulator per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      acc  <= '0;
      cnt  <= '0;
      lost <= 1'b0;
    end else if (start) begin
      sreg <= bin;
      acc  <= '0;
      cnt  <= CW'(DATA_W);
      lost <= 1'b0;
    end else if (cnt != '0) begin
      acc  <= {acc_adj[BW-2:0], sreg[DATA_W-1]};
      sreg <= {sreg[DATA_W-2:0], 1'b0};
      lost <= lost | acc_adj[BW-1];
      cnt  <= cnt - CW'(1);
    end
  end

  // done marks the cycle whose closing edge performs the final step
  assign done = (cnt == CW'(1));
  assign bcd  = {acc[BW-1:BW-4] | {4{lost}}, acc[BW-5:0]};

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment driver: captures a value, converts it (decimal via
// double-dabble or hex nibbles), commits digit codes, and scans them out.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 20,
  parameter int SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  seg_scan_driver_if.slave   bus
);
  localparam int BW    = 4*DIGITS + 4;
  localparam int WW    = (DATA_W > BW) ? DATA_W : BW;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state, state_nxt;
  logic accept, start_dec, commit, bcd_done, busy_q;

  logic [DATA_W-1:0] value_q;
  logic              hex_q, blz_q;
  logic [DIGITS-1:0] dp_q;

  logic [BW-1:0]               bcd;
  logic [WW-1:0]               val_ext;
  logic [DIGITS-1:0][3:0]      nib;
  logic [DIGITS-1:0]           nz;
  logic                        ovf;
  logic [DIGITS-1:0][7:0]      disp, disp_nxt;

  logic [CNT_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DIGITS-1:0] sel_q;
  logic [7:0]        seg_q;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_b2b (
    .clk(clk), .rst(rst), .start(start_dec), .bin(bus.value),
    .done(bcd_done), .bcd(bcd)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_CONV;
      ST_CONV:   if (hex_q || bcd_done) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs; loads are dropped while busy, so nothing queues
  always_comb begin
    accept    = (state == ST_IDLE) && bus.load && !busy_q;
    start_dec = accept && !bus.hex_mode;
    commit    = (state == ST_COMMIT);
  end

  // busy stays up one cycle past COMMIT so it falls when the new digit
  // codes have reached the output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (state_nxt != ST_IDLE) || (state == ST_COMMIT);

  // capture request fields on an accepted load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      value_q <= '0;
      hex_q   <= 1'b0;
      dp_q    <= '0;
      blz_q   <= 1'b0;
    end else if (accept) begin
      value_q <= bus.value;
      hex_q   <= bus.hex_mode;
      dp_q    <= bus.dp_mask;
      blz_q   <= bus.blank_lz;
    end

  assign val_ext = WW'(value_q);
  assign ovf     = hex_q ? |val_ext[WW-1:4*DIGITS] : |bcd[BW-1:BW-4];

  // per-digit encode: dash on overflow, leading-zero blank, then dp overlay
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [7:0] code;
    assign nib[g] = hex_q ? val_ext[4*g +: 4] : bcd[4*g +: 4];
    assign nz[g]  = |nib[g];
    always_comb begin
      if (ovf)                                       code = SEG_DASH;
      else if (blz_q && (g != 0) && ((nz >> g) == '0)) code = SEG_BLANK;
      else                                           code = seg_code(nib[g]);
    end
    assign disp_nxt[g] = {code[7] & ~dp_q[g], code[6:0]};
  end

  // display registers change only in COMMIT, all digits at once
  always_ff @(posedge clk or posedge rst)
    if (rst)         disp <= {DIGITS{SEG_BLANK}};
    else if (commit) disp <= disp_nxt;

  // scan timer and digit index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end

  // sel and seg registered from the same index so they never disagree
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      sel_q <= DIGITS'(1) << idx;
      seg_q <= disp[idx];
    end

  assign bus.busy = busy_q;
  assign bus.sel  = sel_q;
  assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (DIGITS=6, DATA_W=20, SCAN_DIV=4).
module tb_seg_scan_driver;
  localparam int DIGITS   = 6;
  localparam int DATA_W   = 20;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // called on a negedge; load is seen by the following posedge
  task automatic do_load(input logic [19:0] v, input logic hx, input logic [5:0] dp, input logic blz);
    bus.value = v; bus.hex_mode = hx; bus.dp_mask = dp; bus.blank_lz = blz;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic chk_digit(input string tag, input int k, input logic [7:0] exp);
    logic [5:0] want;
    int t;
    want = 6'(1) << k;
    t = 0;
    while (bus.sel !== want && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk($sformatf("%s_sel%0d", tag, k), 32'(bus.sel), 32'(want));
    chk($sformatf("%s_d%0d", tag, k), 32'(bus.seg), 32'(exp));
  endtask

  // expected digits packed as {d5,d4,d3,d2,d1,d0}
  task automatic chk_frame(input string tag, input logic [47:0] e);
    for (int k = 0; k < DIGITS; k++) chk_digit(tag, k, e[8*k +: 8]);
  endtask

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.hex_mode = 1'b0;
    bus.dp_mask = '0; bus.blank_lz = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_sel", 32'(bus.sel), 32'h1);
    chk("rel_seg", 32'(bus.seg), 32'hFF);

    // decimal 123, no blanking
    do_load(20'd123, 1'b0, 6'b0, 1'b0);
    busy_len(n);
    chk("dec_busy", n, 22);
    chk_frame("dec123", {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hB0});

    // leading-zero blanking with dp on a blanked digit
    do_load(20'd123, 1'b0, 6'b001000, 1'b1);
    busy_len(n);
    chk("lz_busy", n, 22);
    chk_frame("lz123", {8'hFF, 8'hFF, 8'h7F, 8'hF9, 8'hA4, 8'hB0});

    // largest value that still fits
    do_load(20'd999999, 1'b0, 6'b0, 1'b0);
    busy_len(n);
    chk_frame("max", {6{8'h90}});

    // overflow -> dashes, dp still overlays
    do_load(20'd1000000, 1'b0, 6'b000001, 1'b0);
    busy_len(n);
    chk_frame("ovf", {{5{8'hBF}}, 8'h3F});

    // hex mode
    do_load(20'hABCDE, 1'b1, 6'b0, 1'b0);
    busy_len(n);
    chk("hex_busy", n, 3);
    chk_frame("hex", {8'hC0, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86});

    // second load two cycles into a conversion is dropped
    do_load(20'd5, 1'b0, 6'b0, 1'b0);
    @(negedge clk);
    bus.value = 20'd9; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    busy_len(n);
    chk("ign_busy", n, 20);
    chk_frame("ign", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h92});
    chk("ign_noqueue", 32'(bus.busy), 32'h0);

    // reset in the middle of a conversion
    do_load(20'd123, 1'b0, 6'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_sel", 32'(bus.sel), 32'h0);
    chk("abort_seg", 32'(bus.seg), 32'hFF);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 32'h0);
    chk_frame("abort", {6{8'hFF}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, giving the number of multiplexed digits (1..8).
REQ-002 The block SHALL have parameter DATA_W, default 20, giving the binary input width (4..27).
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, giving the clk cycles per digit slot (>=2).
REQ-004 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port load  input  1  single-cycle request to capture value, hex_mode, dp_mask and blank_lz.
REQ-007 The block SHALL have port value  input  DATA_W  binary number to display.
REQ-008 The block SHALL have port hex_mode  input  1  1 = hexadecimal nibbles, 0 = decimal.
REQ-009 The block SHALL have port dp_mask  input  DIGITS  1 lights the dp of that digit.
REQ-010 The block SHALL have port blank_lz  input  1  1 blanks leading zeros.
REQ-011 The block SHALL have port busy  output  1  conversion in progress.
REQ-012 The block SHALL have port sel  output  DIGITS  one-hot active-high digit select; bit0 is the least significant digit.
REQ-013 The block SHALL have port seg  output  8  active-low segments; bit7 = dp, bits6..0 = g..a.

Function
REQ-014 The FSM SHALL have states IDLE, CONV and COMMIT, and SHALL reset to IDLE.
REQ-015 In IDLE, load=1 SHALL capture all inputs and SHALL enter CONV on the next edge; busy SHALL be 1 in CONV and COMMIT.
REQ-016 load asserted while busy=1 SHALL be ignored entirely, with no queuing.
REQ-017 Decimal CONV SHALL run sequential double-dabble (add-3 then shift, one bit per cycle) for exactly DATA_W cycles.
REQ-018 Hex CONV SHALL last exactly 1 cycle, with nibble i mapped to digit i.
REQ-019 COMMIT SHALL last 1 cycle, SHALL copy the result into the display registers atomically, and SHALL then return to IDLE.
REQ-020 Total latency from the load edge to busy=0 SHALL be DATA_W+2 cycles in decimal mode and 3 cycles in hex mode.
REQ-021 If the value needs more than DIGITS digits (decimal: value >= 10^DIGITS; hex: nonzero nibble above DIGITS-1), every digit SHALL display dash 8'hBF, and dp SHALL still follow dp_mask.
REQ-022 Segment codes SHALL be: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E; blank SHALL be FF.
REQ-023 With blank_lz=1, each digit above the most significant nonzero digit SHALL be blank, digit0 SHALL never be blanked, and a dp_mask bit SHALL still clear bit7 on a blanked digit.
REQ-024 A scan counter SHALL count 0..SCAN_DIV-1; at wrap, the digit index SHALL advance 0..DIGITS-1 and then return to 0.
REQ-025 sel and seg SHALL be registered together, both SHALL reflect the current index one cycle after it changes, and no cycle SHALL show sel and seg from different digits.
REQ-026 Scanning SHALL continue during CONV and SHALL show the previous committed value until COMMIT.
REQ-027 Before the first COMMIT after reset, every digit SHALL show blank (FF).

Reset
REQ-028 While rst=1: sel=0, seg=8'hFF, busy=0, FSM=IDLE, scan counter and digit index=0, display registers=blank.
REQ-029 rst asserted mid-CONV SHALL discard the conversion; after release no stale result SHALL appear.
REQ-030 The first sel after reset release SHALL be 1 (digit0), asserted within 2 cycles.

Structure
REQ-031 Package seg_pkg SHALL hold the 16 segment-code constants, SEG_BLANK, SEG_DASH and the FSM state encoding.
REQ-032 Sub-module bin2bcd_seq SHALL contain the double-dabble datapath, with ports start, bin, done and bcd[4*DIGITS+3:0]; the extra nibble is used for overflow detection.
REQ-033 The top level SHALL hold the FSM, the capture registers, the scan counter and the output registers.

Verification (DIGITS=6, DATA_W=20, SCAN_DIV=4)
REQ-034 rst=1 for 3 cycles -> sel=000000, seg=FF, busy=0; after release, sel=000001 with seg=FF.
REQ-035 load value=123, hex_mode=0, blank_lz=0 -> busy high for 22 cycles; then digit0..5 = B0, A4, F9, C0, C0, C0.
REQ-036 Same load with blank_lz=1, dp_mask=001000 -> digit0..2 = B0, A4, F9; digit3=7F; digit4..5=FF.
REQ-037 load value=1000000 decimal -> all digits BF; then load value=0xABCDE, hex_mode=1 -> busy for 3 cycles; digit0..4 = 86, A1, C6, 83, 88; digit5=C0.
REQ-038 load value=5, then a second load value=9 two cycles later -> the second load is ignored and digit0 = 92 after COMMIT.
REQ-039 rst pulsed at CONV cycle 10 -> busy=0 and all digits FF, with no digit showing the aborted value.
